// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - write-back arbiter merging pipe and long-latency results into the regfile write port
//
// Purpose:
//   Drives the single integer register file write port (wn/d/we). Pipe results
//   always win the port; long-latency results are queued in an in-order FIFO
//   and drained whenever the pipe leaves the port free. A 32-bit pending
//   scoreboard tracks registers with an outstanding long-latency result.
//
// Configuration macro:
//   WB_BYPASS_EN - when defined, a long-latency result arriving while the pipe
//                  is idle and the FIFO is empty is written straight through
//                  without being queued.
//
// Ports:
//   clk, clrn                   clock, asynchronous active-low reset
//   pa_we, pa_wn, pa_d          pipe result (no back-pressure)
//   lb_valid, lb_wn, lb_d       long-latency result, accepted when lb_ready
//   lb_ready                    FIFO not full
//   sb_set, sb_set_wn           mark a register pending at issue
//   sb_rna/sb_rnb               scoreboard query registers
//   sb_busy_a/sb_busy_b         pending state of the queried registers
//   wn, d, we                   regfile write port
//   fifo_count                  FIFO occupancy, 0..DEPTH

module wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             pa_we,
  input  logic [4:0]       pa_wn,
  input  logic [31:0]      pa_d,
  input  logic             lb_valid,
  input  logic [4:0]       lb_wn,
  input  logic [31:0]      lb_d,
  output logic             lb_ready,
  input  logic             sb_set,
  input  logic [4:0]       sb_set_wn,
  input  logic [4:0]       sb_rna,
  input  logic [4:0]       sb_rnb,
  output logic             sb_busy_a,
  output logic             sb_busy_b,
  output logic [4:0]       wn,
  output logic [31:0]      d,
  output logic             we,
  output logic [PTR_W:0]   fifo_count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [4:0]       fifo_wn_q [DEPTH];
  logic [4:0]       fifo_wn_d [DEPTH];
  logic [31:0]      fifo_dat_q [DEPTH];
  logic [31:0]      fifo_dat_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [31:0]      pending_q, pending_d;

  logic             pipe_win;
  logic             fifo_empty;
  logic             fifo_full;
  logic             bypass;
  logic             push;
  logic             pop;
  logic [4:0]       head_wn;
  logic [31:0]      head_d;

  // Port arbitration and FIFO handshake
  always_comb begin
    pipe_win   = pa_we && (pa_wn != 5'd0);
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FULL_CNT);
    head_wn    = fifo_wn_q[rd_ptr_q];
    head_d     = fifo_dat_q[rd_ptr_q];

`ifdef WB_BYPASS_EN
    bypass = !pipe_win && fifo_empty && lb_valid;
`else
    bypass = 1'b0;
`endif

    // A head with wn==0 still pops; it just never asserts we.
    pop  = !pipe_win && !fifo_empty;
    // Full blocks the push even if a pop frees a slot at the same edge.
    push = lb_valid && !fifo_full && !bypass;

    lb_ready = !fifo_full;

    we = 1'b0;
    wn = 5'd0;
    d  = 32'd0;
    if (pipe_win) begin
      we = 1'b1;
      wn = pa_wn;
      d  = pa_d;
    end else if (!fifo_empty) begin
      we = (head_wn != 5'd0);
      wn = head_wn;
      d  = head_d;
    end else if (bypass) begin
      we = (lb_wn != 5'd0);
      wn = lb_wn;
      d  = lb_d;
    end
  end

  // FIFO next state
  always_comb begin
    fifo_wn_d  = fifo_wn_q;
    fifo_dat_d = fifo_dat_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (push) begin
      fifo_wn_d[wr_ptr_q]  = lb_wn;
      fifo_dat_d[wr_ptr_q] = lb_d;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Scoreboard next state; the set is applied last so it wins over a clear
  always_comb begin
    pending_d = pending_q;
    if (pop && (head_wn != 5'd0)) begin
      pending_d[head_wn] = 1'b0;
    end
    if (bypass && (lb_wn != 5'd0)) begin
      pending_d[lb_wn] = 1'b0;
    end
    if (sb_set && (sb_set_wn != 5'd0)) begin
      pending_d[sb_set_wn] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Queries see registered state only, never this cycle's clear
  always_comb begin
    sb_busy_a  = pending_q[sb_rna];
    sb_busy_b  = pending_q[sb_rnb];
    fifo_count = count_q;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_wn_q[i]  <= 5'd0;
        fifo_dat_q[i] <= 32'd0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= 32'd0;
    end else begin
      fifo_wn_q  <= fifo_wn_d;
      fifo_dat_q <= fifo_dat_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter

module tb_wb_arbiter;

  logic        clk;
  logic        clrn;
  logic        pa_we;
  logic [4:0]  pa_wn;
  logic [31:0] pa_d;
  logic        lb_valid;
  logic [4:0]  lb_wn;
  logic [31:0] lb_d;
  logic        lb_ready;
  logic        sb_set;
  logic [4:0]  sb_set_wn;
  logic [4:0]  sb_rna;
  logic [4:0]  sb_rnb;
  logic        sb_busy_a;
  logic        sb_busy_b;
  logic [4:0]  wn;
  logic [31:0] d;
  logic        we;
  logic [2:0]  fifo_count;

  int n_vec;
  int n_err;

  wb_arbiter #(.DEPTH(4), .PTR_W(2)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .pa_we      (pa_we),
    .pa_wn      (pa_wn),
    .pa_d       (pa_d),
    .lb_valid   (lb_valid),
    .lb_wn      (lb_wn),
    .lb_d       (lb_d),
    .lb_ready   (lb_ready),
    .sb_set     (sb_set),
    .sb_set_wn  (sb_set_wn),
    .sb_rna     (sb_rna),
    .sb_rnb     (sb_rnb),
    .sb_busy_a  (sb_busy_a),
    .sb_busy_b  (sb_busy_b),
    .wn         (wn),
    .d          (d),
    .we         (we),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pa_we     = 1'b0;
    pa_wn     = 5'd0;
    pa_d      = 32'd0;
    lb_valid  = 1'b0;
    lb_wn     = 5'd0;
    lb_d      = 32'd0;
    sb_set    = 1'b0;
    sb_set_wn = 5'd0;
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    clrn   = 1'b0;
    sb_rna = 5'd0;
    sb_rnb = 5'd0;
    idle();
    tick();
    tick();

    // Reset state
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ready", 32'(lb_ready), 32'd1);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_wn", 32'(wn), 32'd0);
    chk("rst_d", d, 32'd0);
    clrn = 1'b1;
    tick();

    // Queue 3 entries behind a busy pipe, then reset mid-operation
    for (int i = 0; i < 3; i++) begin
      pa_we = 1'b1; pa_wn = 5'd1; pa_d = 32'h1;
      lb_valid = 1'b1; lb_wn = 5'(10 + i); lb_d = 32'(100 + i);
      sb_set = 1'b1; sb_set_wn = 5'(10 + i);
      tick();
    end
    chk("q3_count", 32'(fifo_count), 32'd3);
    idle();
    clrn = 1'b0;
    #1;
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_we", 32'(we), 32'd0);
    chk("mid_rst_ready", 32'(lb_ready), 32'd1);
    for (int r = 0; r < 32; r++) begin
      sb_rna = 5'(r);
      #1;
      chk($sformatf("mid_rst_busy_r%0d", r), 32'(sb_busy_a), 32'd0);
    end
    clrn = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("post_rst_no_write", 32'(we), 32'd0);
      tick();
    end

    // Pipe only
    pa_we = 1'b1; pa_wn = 5'd5; pa_d = 32'hDEADBEEF;
    #1;
    chk("pipe_we", 32'(we), 32'd1);
    chk("pipe_wn", 32'(wn), 32'd5);
    chk("pipe_d", d, 32'hDEADBEEF);
    pa_wn = 5'd0;
    #1;
    chk("pipe_r0_we", 32'(we), 32'd0);
    tick();
    idle();

    // Collision: pipe r3 and lb r7 in the same cycle
    pa_we = 1'b1; pa_wn = 5'd3; pa_d = 32'h33;
    lb_valid = 1'b1; lb_wn = 5'd7; lb_d = 32'h11;
    #1;
    chk("col_c0_wn", 32'(wn), 32'd3);
    chk("col_c0_d", d, 32'h33);
    chk("col_c0_we", 32'(we), 32'd1);
    tick();
    chk("col_count1", 32'(fifo_count), 32'd1);
    // Pipe idle with another lb result: pop and push together
    idle();
    lb_valid = 1'b1; lb_wn = 5'd8; lb_d = 32'h22;
    #1;
    chk("col_c1_we", 32'(we), 32'd1);
    chk("col_c1_wn", 32'(wn), 32'd7);
    chk("col_c1_d", d, 32'h11);
    tick();
    chk("pushpop_count", 32'(fifo_count), 32'd1);
    idle();
    #1;
    chk("col_c2_wn", 32'(wn), 32'd8);
    chk("col_c2_d", d, 32'h22);
    tick();
    chk("col_count0", 32'(fifo_count), 32'd0);
    chk("col_idle_we", 32'(we), 32'd0);

    // Full: continuous pipe writes while offering 5 lb results
    for (int i = 0; i < 5; i++) begin
      pa_we = 1'b1; pa_wn = 5'd2; pa_d = 32'h2;
      lb_valid = 1'b1; lb_wn = 5'(20 + i); lb_d = 32'(200 + i);
      #1;
      chk($sformatf("full_ready_%0d", i), 32'(lb_ready), (i < 4) ? 32'd1 : 32'd0);
      tick();
    end
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_ready", 32'(lb_ready), 32'd0);
    // Pipe drops while r24 is still offered: pop happens, push must not
    pa_we = 1'b0; pa_wn = 5'd0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("drain_we_%0d", i), 32'(we), 32'd1);
      chk($sformatf("drain_wn_%0d", i), 32'(wn), 32'(20 + i));
      chk($sformatf("drain_d_%0d", i), d, 32'(200 + i));
      tick();
      if (i == 0) begin
        chk("full_pop_no_push", 32'(fifo_count), 32'd3);
        lb_valid = 1'b0;
      end
    end
    chk("drain_count", 32'(fifo_count), 32'd0);

    // Head with wn==0 is popped without a write
    pa_we = 1'b1; pa_wn = 5'd6; lb_valid = 1'b1; lb_wn = 5'd0; lb_d = 32'h5A;
    tick();
    idle();
    #1;
    chk("r0_head_we", 32'(we), 32'd0);
    tick();
    chk("r0_head_popped", 32'(fifo_count), 32'd0);

    // Scoreboard set, then clear at the pop edge
    sb_rna = 5'd9; sb_rnb = 5'd0;
    sb_set = 1'b1; sb_set_wn = 5'd9;
    tick();
    idle();
    chk("sb_busy_set", 32'(sb_busy_a), 32'd1);
    chk("sb_r0_never", 32'(sb_busy_b), 32'd0);
    tick();
    pa_we = 1'b1; pa_wn = 5'd9; pa_d = 32'h9;
    lb_valid = 1'b1; lb_wn = 5'd9; lb_d = 32'h99;
    tick();
    idle();
    chk("sb_busy_pipe_no_clear", 32'(sb_busy_a), 32'd1);
    #1;
    chk("sb_busy_pop_cycle", 32'(sb_busy_a), 32'd1);
    chk("sb_pop_wn", 32'(wn), 32'd9);
    tick();
    chk("sb_busy_cleared", 32'(sb_busy_a), 32'd0);

    // Set and clear r9 on the same edge: set wins
    sb_set = 1'b1; sb_set_wn = 5'd9;
    tick();
    idle();
    pa_we = 1'b1; pa_wn = 5'd1; lb_valid = 1'b1; lb_wn = 5'd9; lb_d = 32'h77;
    tick();
    idle();
    sb_set = 1'b1; sb_set_wn = 5'd9;
    tick();
    idle();
    sb_rnb = 5'd9;
    #1;
    chk("sb_set_wins_a", 32'(sb_busy_a), 32'd1);
    chk("sb_set_wins_b", 32'(sb_busy_b), 32'd1);
    chk("sb_set_wins_count", 32'(fifo_count), 32'd0);

    // Empty FIFO, idle pipe, lb result for r4 with r4 pending
    sb_set = 1'b1; sb_set_wn = 5'd4;
    tick();
    idle();
    sb_rna = 5'd4;
    lb_valid = 1'b1; lb_wn = 5'd4; lb_d = 32'h44;
    #1;
`ifdef WB_BYPASS_EN
    chk("byp_we", 32'(we), 32'd1);
    chk("byp_wn", 32'(wn), 32'd4);
    chk("byp_d", d, 32'h44);
    tick();
    idle();
    chk("byp_count", 32'(fifo_count), 32'd0);
    chk("byp_busy_clear", 32'(sb_busy_a), 32'd0);
`else
    chk("nobyp_we", 32'(we), 32'd0);
    tick();
    idle();
    chk("nobyp_count", 32'(fifo_count), 32'd1);
    chk("nobyp_busy", 32'(sb_busy_a), 32'd1);
    #1;
    chk("nobyp_we_next", 32'(we), 32'd1);
    chk("nobyp_wn_next", 32'(wn), 32'd4);
    chk("nobyp_d_next", d, 32'h44);
    tick();
    chk("nobyp_busy_clear", 32'(sb_busy_a), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
